snapshot_sequencer: RTL and testbench
=====================================

Name: snapshot_sequencer

Overview:
Sequences save/load requests raised by the VGA controller against a small circular buffer of sensor snapshots, and hands results to the processor over a level handshake. It sits between vga_controller (request side) and processor_skeleton (consumer), replacing the direct save_signal/load_signal/sensor_input_to_save wiring. It owns buffer pointers, occupancy, overwrite policy and request priority.

Parameters:
DATA_W, 24, snapshot width; only the LSB 24 bits of the 32-bit sensor bus are meaningful
DEPTH, 4, number of snapshot slots; power of two
PTR_W, 2, log2(DEPTH)

Ports:
clock  input  1  system clock; all logic is on the rising edge
resetn  input  1  asynchronous, active-low reset
sensor_input  input  32  live sensor bus; bits [DATA_W-1:0] are captured
save_req  input  1  level request from VGA side; a rising edge requests one save
load_req  input  1  level request from VGA side; a rising edge requests one load
load_idx  input  PTR_W  age of the slot to load; 0 = newest
proc_ack  input  1  processor acknowledge for the current notification
sensor_input_to_save  output  32  zero-extended snapshot data (save: value written; load: value read)
save_signal  output  32  bit0 = save notification; bits [31:1] = 0
load_signal  output  32  bit0 = load notification; bits [31:1] = 0
count  output  PTR_W+1  occupied slots, 0..DEPTH
overflow  output  1  sticky; set when a save overwrites the oldest slot
load_err  output  1  one-cycle pulse when a load is rejected
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0; wr_ptr=0; count=0; overflow=0; pending flags cleared; edge-detect registers cleared; FSM=IDLE; buffer contents need not be cleared.
- Edge detect: a save edge is save_req=1 with the registered previous value 0; load edge is detected the same way. An edge occurring while busy sets a pending flag. One pending flag per type; further edges while that flag is set are dropped.
- FSM states: IDLE, SAVE_WR, SAVE_NOTIFY, LOAD_RD, LOAD_NOTIFY.
- IDLE: a save edge or pending save goes to SAVE_WR. Otherwise a load edge or pending load goes to LOAD_RD. Save has priority when both are present; the load stays pending. Consuming a request clears its pending flag.
- SAVE_WR (1 cycle): buf[wr_ptr] <= sensor_input[DATA_W-1:0]; sensor_input_to_save <= same value, zero-extended; wr_ptr increments modulo DEPTH.
  - If count<DEPTH, count increments.
  - If count==DEPTH, count is unchanged, the oldest slot is overwritten, and overflow is set.
  - Next state is SAVE_NOTIFY.
- SAVE_NOTIFY: save_signal[0]=1 and held. On the first cycle proc_ack=1 is sampled, the FSM goes to IDLE and save_signal[0]=0 from the next cycle.
- Save latency: edge in cycle t gives save_signal[0]=1 from cycle t+2.
- LOAD_RD (1 cycle):
  - If load_idx >= count (including count==0): pulse load_err for one cycle, go to IDLE, load_signal stays 0.
  - Otherwise sensor_input_to_save <= buf[(wr_ptr-1-load_idx) mod DEPTH], zero-extended, and next state is LOAD_NOTIFY.
- LOAD_NOTIFY: load_signal[0]=1, held until proc_ack is sampled high, then return to IDLE. Load latency is the same as save (t+2).
- sensor_input_to_save holds its last value outside the write/read states.
- proc_ack while in IDLE, SAVE_WR or LOAD_RD is ignored.
- load_idx is sampled only in LOAD_RD.
- Back-to-back operation: there is at least one IDLE cycle between consecutive operations.
- Reset asserted mid-operation aborts immediately; no partial notification survives.

Test Plan:
- Reset, then sensor_input=0x00ABCDEF, save_req 0→1 at cycle t → save_signal=1 at t+2, sensor_input_to_save=0x00ABCDEF, count=1; proc_ack=1 for one cycle → save_signal=0 the next cycle, FSM returns to IDLE.
- Save values 1,2,3,4,5 (ack each) → count=4, overflow=1; load_idx=0 → 5; load_idx=3 → 2.
- After reset, load edge with count=0 → load_err high for exactly 1 cycle, load_signal stays 0, count=0.
- Save and load edges in the same cycle with count=1 → save is serviced first; the load runs after ack; the load returns the new snapshot for load_idx=0 and the older one for load_idx=1.
- Extra save edge during SAVE_NOTIFY, then a third edge before the ack → exactly one extra save is performed (count increments by 2 total).
- resetn low during LOAD_NOTIFY → load_signal=0, count=0, overflow=0 immediately; the next save writes slot 0.

Source files
------------

// File: rtl/snapshot_sequencer.sv
// rtl/snapshot_sequencer.sv - save/load sequencer over a circular snapshot buffer
module snapshot_sequencer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [31:0]        sensor_input,
    input  logic               save_req,
    input  logic               load_req,
    input  logic [PTR_W-1:0]   load_idx,
    input  logic               proc_ack,
    output logic [31:0]        sensor_input_to_save,
    output logic [31:0]        save_signal,
    output logic [31:0]        load_signal,
    output logic [PTR_W:0]     count,
    output logic               overflow,
    output logic               load_err,
    output logic               busy
);

    localparam int                 PAD_W    = 32 - DATA_W;
    localparam logic [PTR_W-1:0]   PTR_ONE  = 1;
    localparam logic [PTR_W:0]     CNT_ONE  = 1;
    localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE_WR,
        S_SAVE_NOTIFY,
        S_LOAD_RD,
        S_LOAD_NOTIFY
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] snap_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              save_prev, load_prev;
    logic              save_pend, load_pend;
    logic              save_edge, load_edge;
    logic              take_save, take_load;
    logic              load_bad;
    logic              sensor_unused;

    // Upper sensor bits carry nothing we store.
    assign sensor_unused = ^sensor_input[31:DATA_W];

    assign save_edge = save_req & ~save_prev;
    assign load_edge = load_req & ~load_prev;

    // Save wins in IDLE; a simultaneous load edge falls through to its pending flag.
    assign take_save = (state == S_IDLE) && (save_edge || save_pend);
    assign take_load = (state == S_IDLE) && !take_save && (load_edge || load_pend);

    // Newest slot sits just behind wr_ptr; the subtraction wraps modulo DEPTH.
    assign rd_ptr   = wr_ptr - PTR_ONE - load_idx;
    assign load_bad = ({1'b0, load_idx} >= count);

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; proc_ack only matters in the notify states.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (take_save) begin
                    state_nxt = S_SAVE_WR;
                end else if (take_load) begin
                    state_nxt = S_LOAD_RD;
                end
            end
            S_SAVE_WR:     state_nxt = S_SAVE_NOTIFY;
            S_SAVE_NOTIFY: if (proc_ack) state_nxt = S_IDLE;
            S_LOAD_RD:     state_nxt = load_bad ? S_IDLE : S_LOAD_NOTIFY;
            S_LOAD_NOTIFY: if (proc_ack) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    // Notification, error and busy outputs decoded from the current state.
    always_comb begin
        save_signal = '0;
        load_signal = '0;
        load_err    = 1'b0;
        busy        = (state != S_IDLE);
        save_signal[0] = (state == S_SAVE_NOTIFY);
        load_signal[0] = (state == S_LOAD_NOTIFY);
        if (state == S_LOAD_RD) begin
            load_err = load_bad;
        end
    end

    // Edge detect, pending flags, pointer/occupancy bookkeeping and result register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            save_prev            <= 1'b0;
            load_prev            <= 1'b0;
            save_pend            <= 1'b0;
            load_pend            <= 1'b0;
            wr_ptr               <= '0;
            count                <= '0;
            overflow             <= 1'b0;
            sensor_input_to_save <= '0;
        end else begin
            save_prev <= save_req;
            load_prev <= load_req;
            // A repeat edge while a flag is already set simply leaves it set.
            save_pend <= take_save ? 1'b0 : (save_pend | save_edge);
            load_pend <= take_load ? 1'b0 : (load_pend | load_edge);

            if (state == S_SAVE_WR) begin
                sensor_input_to_save <= {{PAD_W{1'b0}}, sensor_input[DATA_W-1:0]};
                wr_ptr               <= wr_ptr + PTR_ONE;
                if (count == CNT_FULL) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + CNT_ONE;
                end
            end

            if (state == S_LOAD_RD && !load_bad) begin
                sensor_input_to_save <= {{PAD_W{1'b0}}, snap_mem[rd_ptr]};
            end
        end
    end

    // Snapshot storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (state == S_SAVE_WR) begin
            snap_mem[wr_ptr] <= sensor_input[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_snapshot_sequencer.sv
// tb/tb_snapshot_sequencer.sv - directed self-checking bench for snapshot_sequencer
module tb_snapshot_sequencer;

    logic        clock;
    logic        resetn;
    logic [31:0] sensor_input;
    logic        save_req;
    logic        load_req;
    logic [1:0]  load_idx;
    logic        proc_ack;
    logic [31:0] sensor_input_to_save;
    logic [31:0] save_signal;
    logic [31:0] load_signal;
    logic [2:0]  count;
    logic        overflow;
    logic        load_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    snapshot_sequencer dut (
        .clock                (clock),
        .resetn               (resetn),
        .sensor_input         (sensor_input),
        .save_req             (save_req),
        .load_req             (load_req),
        .load_idx             (load_idx),
        .proc_ack             (proc_ack),
        .sensor_input_to_save (sensor_input_to_save),
        .save_signal          (save_signal),
        .load_signal          (load_signal),
        .count                (count),
        .overflow             (overflow),
        .load_err             (load_err),
        .busy                 (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        save_req     = 1'b0;
        load_req     = 1'b0;
        proc_ack     = 1'b0;
        load_idx     = 2'd0;
        sensor_input = 32'd0;
        resetn       = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic do_save(input logic [31:0] v, input logic [31:0] exp_data, input logic [2:0] exp_cnt);
        sensor_input = v;
        save_req     = 1'b1;
        tick();
        check("save_wr_busy", {31'd0, busy}, 32'd1);
        check("save_wr_sig", save_signal, 32'd0);
        save_req = 1'b0;
        tick();
        check("save_notify_sig", save_signal, 32'd1);
        check("save_data", sensor_input_to_save, exp_data);
        check("save_count", {29'd0, count}, {29'd0, exp_cnt});
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        check("save_ack_sig", save_signal, 32'd0);
        check("save_ack_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_load(input logic [1:0] idx, input logic [31:0] exp_data);
        load_idx = idx;
        load_req = 1'b1;
        tick();
        check("load_rd_err", {31'd0, load_err}, 32'd0);
        load_req = 1'b0;
        tick();
        check("load_notify_sig", load_signal, 32'd1);
        check("load_data", sensor_input_to_save, exp_data);
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        check("load_ack_sig", load_signal, 32'd0);
    endtask

    initial begin
        // Reset state
        apply_reset();
        check("rst_save_sig", save_signal, 32'd0);
        check("rst_load_sig", load_signal, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", sensor_input_to_save, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);

        // Single save with two-cycle latency
        do_save(32'h00ABCDEF, 32'h00ABCDEF, 3'd1);

        // Fill past depth, then read newest and oldest
        apply_reset();
        do_save(32'd1, 32'd1, 3'd1);
        do_save(32'd2, 32'd2, 3'd2);
        do_save(32'd3, 32'd3, 3'd3);
        do_save(32'd4, 32'd4, 3'd4);
        check("pre_overflow", {31'd0, overflow}, 32'd0);
        do_save(32'd5, 32'd5, 3'd4);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        do_load(2'd0, 32'd5);
        do_load(2'd3, 32'd2);
        do_load(2'd1, 32'd4);
        check("fill_count", {29'd0, count}, 32'd4);

        // Load from an empty buffer is rejected for exactly one cycle
        apply_reset();
        load_idx = 2'd0;
        load_req = 1'b1;
        tick();
        check("empty_err_pulse", {31'd0, load_err}, 32'd1);
        check("empty_load_sig", load_signal, 32'd0);
        load_req = 1'b0;
        tick();
        check("empty_err_drop", {31'd0, load_err}, 32'd0);
        check("empty_load_sig2", load_signal, 32'd0);
        check("empty_count", {29'd0, count}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);

        // Simultaneous save and load: save first, load stays pending
        do_save(32'h11, 32'h11, 3'd1);
        sensor_input = 32'h22;
        load_idx     = 2'd0;
        save_req     = 1'b1;
        load_req     = 1'b1;
        tick();
        save_req = 1'b0;
        load_req = 1'b0;
        tick();
        check("both_save_sig", save_signal, 32'd1);
        check("both_load_sig", load_signal, 32'd0);
        check("both_save_data", sensor_input_to_save, 32'h22);
        check("both_count", {29'd0, count}, 32'd2);
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        check("both_idle_gap", {31'd0, busy}, 32'd0);
        tick();
        check("both_load_rd_sig", load_signal, 32'd0);
        check("both_load_rd_err", {31'd0, load_err}, 32'd0);
        tick();
        check("both_load_sig2", load_signal, 32'd1);
        check("both_load_data", sensor_input_to_save, 32'h22);
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        do_load(2'd1, 32'h11);

        // Edges during SAVE_NOTIFY: one pending save, further edge dropped
        sensor_input = 32'h33;
        save_req     = 1'b1;
        tick();
        save_req = 1'b0;
        tick();
        check("extra_notify1", save_signal, 32'd1);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        tick();
        sensor_input = 32'hFF000044;
        save_req     = 1'b1;
        tick();
        save_req = 1'b0;
        check("extra_hold", save_signal, 32'd1);
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        check("extra_idle", {31'd0, busy}, 32'd0);
        tick();
        check("extra_save_wr", {31'd0, busy}, 32'd1);
        tick();
        check("extra_notify2", save_signal, 32'd1);
        check("extra_zero_ext", sensor_input_to_save, 32'h00000044);
        check("extra_count", {29'd0, count}, 32'd4);
        proc_ack = 1'b1;
        tick();
        proc_ack = 1'b0;
        tick();
        check("extra_no_third", {31'd0, busy}, 32'd0);
        check("extra_count2", {29'd0, count}, 32'd4);

        // Reset during LOAD_NOTIFY aborts immediately
        do_save(32'h55, 32'h55, 3'd4);
        check("abort_ovf_pre", {31'd0, overflow}, 32'd1);
        load_idx = 2'd0;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        check("abort_load_sig", load_signal, 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_load_drop", load_signal, 32'd0);
        check("abort_count", {29'd0, count}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        do_save(32'h66, 32'h66, 3'd1);
        do_load(2'd0, 32'h66);
        load_idx = 2'd1;
        load_req = 1'b1;
        tick();
        check("post_rst_err", {31'd0, load_err}, 32'd1);
        load_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
